data_memory_be: RTL

//  Parametrised byte-addressable RV32 data memory with a valid/ready request port and registered response.

---
 rtl/data_memory_be.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressable RV32 data memory with a valid/ready request
// port and a registered, one-cycle response.
// It handles the RV32 stores SB/SH/SW and loads LB/LH/LW/LBU/LHU, selected by
// funct3. Stores merge only the addressed bytes into the word. Loads return
// sign- or zero-extended data.
// Misaligned, out-of-range and illegal requests are faulted, and a faulted
// request never writes the array.
// When CLEAR_ON_RESET is set, the array is swept to zero after reset, one word
// per cycle.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req_valid     request present
//   req_ready     combinational: high only in IDLE while rst is low
//   req_write     1 = store, 0 = load
//   req_funct3    RV32 load/store funct3
//   req_addr      byte address
//   req_wdata     store data, low-aligned
//   rsp_valid     one-cycle pulse for each accepted request
//   rsp_rdata     extended load data; 0 for stores and faults
//   rsp_fault     request rejected, no array write
module data_memory_be #(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   clr_cnt;
    logic            clr_last;
    logic            clear_we;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     off;
    logic [IW-1:0]   idx;
    logic [1:0]      lane;
    logic            f3_legal;
    logic            misalign;
    logic            out_of_range;
    logic            fault;
    logic            accept;
    logic            do_store;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_sh;
    logic [31:0]     rd_word;
    logic [31:0]     rd_sh;
    logic [31:0]     load_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep counter; restarts from zero on every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + IW'(1);
        end
    end

    assign clr_last = (clr_cnt == IW'(DEPTH_WORDS - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_last) state_nxt = S_IDLE;
            S_IDLE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; rst gates them so nothing is accepted or cleared in a reset cycle
    always_comb begin
        req_ready = 1'b0;
        clear_we  = 1'b0;
        case (state)
            S_IDLE:  req_ready = ~rst;
            S_CLEAR: clear_we  = ~rst;
            default: ;
        endcase
    end

    // Address decode and fault classification
    always_comb begin
        off          = req_addr - ADDR_BASE;
        idx          = off[IW+1:2];
        lane         = off[1:0];
        f3_legal     = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                 f3_legal = 1'b0;
        endcase
        misalign     = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
        // Addresses below ADDR_BASE wrap to large offsets and land here too
        out_of_range = ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
        fault        = ~f3_legal | (req_write & req_funct3[2]) | misalign | out_of_range;
    end

    assign accept   = req_valid & req_ready;
    assign do_store = accept & req_write & ~fault;

    // Store lane enables and data moved into the addressed lanes
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
        wdata_sh = req_wdata << {lane, 3'b000};
    end

    // Array write: sweep has priority, but it never overlaps with an accept
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_cnt] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Load extraction and extension
    always_comb begin
        rd_word = mem[idx];
        rd_sh   = rd_word >> {lane, 3'b000};
        case (req_funct3)
            3'b000:  load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h000000, rd_sh[7:0]};
            3'b101:  load_data = {16'h0000, rd_sh[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Registered response; data and fault hold between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_fault <= fault;
                rsp_rdata <= (fault || req_write) ? 32'h0000_0000 : load_data;
            end
        end
    end

endmodule
